filtro_media_bcd: RTL and testbench
===================================

FILTRO_MEDIA_BCD -- requirements
Module: filtro_media_bcd

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of moving-average window depth; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  input  12  unsigned ADC sample from the ADC controller.
REQ-005 SHALL have port din_valid  input  1  one-cycle strobe; din is sampled when high.
REQ-006 SHALL have port media  output  12  current moving average.
REQ-007 SHALL have port bcd  output  16  four BCD digits of the last converted average: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-008 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd is updated.
REQ-009 SHALL have port busy  output  1  high whenever the conversion FSM is not in IDLE.

Function
REQ-010 SHALL hold a circular buffer of 2^AVG_LOG2 12-bit entries, a write pointer of AVG_LOG2 bits and a running sum of 12+AVG_LOG2 bits.
REQ-011 SHALL, on an edge with din_valid=1: sum <= sum + din - buf[ptr]; buf[ptr] <= din; ptr <= ptr+1, wrapping from 2^AVG_LOG2-1 to 0.
REQ-012 SHALL accept din_valid in every FSM state; the filter update never stalls and never drops a sample.
REQ-013 SHALL drive media = sum >> AVG_LOG2 (truncation, no rounding), so media reflects a sample from the edge that sampled it onward.
REQ-014 SHALL treat the buffer as zero-filled after reset; averages ramp up during the first 2^AVG_LOG2 samples (no fill compensation).
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 SHALL transition IDLE->LOAD on din_valid=1; otherwise remain in IDLE.
REQ-017 SHALL, in LOAD, capture media into a 12-bit shift register, clear the 28-bit double-dabble work register's BCD part and the iteration counter, then go to SHIFT.
REQ-018 SHALL, in SHIFT, perform one double-dabble iteration per cycle (each BCD nibble >=5 gets +3, then shift left by 1), 12 iterations, then go to DONE.
REQ-019 SHALL, in DONE, load bcd from the work register and pulse bcd_valid high for exactly one cycle.
REQ-020 SHALL fix the latency at 14 rising edges: bcd and bcd_valid update on the 14th edge after the edge that sampled din_valid in IDLE.
REQ-021 SHALL set a pending flag on din_valid while in LOAD, SHIFT or DONE; DONE goes to LOAD and clears the flag if it is set or din_valid=1 that cycle, otherwise goes to IDLE.
REQ-022 SHALL keep at most one pending request; multiple strobes during a conversion produce a single follow-up conversion using the latest media.
REQ-023 SHALL hold bcd constant between bcd_valid pulses.
REQ-024 SHALL produce digits in the range 0..9 only; the maximum input 4095 yields 16'h4095.

Reset
REQ-025 SHALL, on reset low, immediately clear the buffer, ptr, sum, pending flag, shift/work registers and counter; set FSM to IDLE; drive media=0, bcd=0, bcd_valid=0, busy=0.
REQ-026 SHALL abort any conversion in progress on reset, with no bcd_valid pulse generated for it.
REQ-027 SHALL operate normally from the first rising edge after reset is released.

Verification
REQ-028 Reset with random prior state -> media=0, bcd=16'h0000, bcd_valid=0, busy=0.
REQ-029 AVG_LOG2=3, single din=2000 strobe after reset -> media=250 after the sampling edge, busy=1 the next cycle, bcd=16'h0250 with bcd_valid high for one cycle on edge +14.
REQ-030 Eight strobes of din=4095 spaced 20 cycles -> media 511,1023,1535,2047,2559,3071,3583,4095; last bcd=16'h4095.
REQ-031 Wrap: eight strobes of 1000, then eight of 0 -> media ramps 125..1000, then 875..0; final bcd=16'h0000; ptr returns to 0.
REQ-032 Three strobes on consecutive cycles (din=800, 1600, 2400 from reset) -> exactly two bcd_valid pulses: 16'h0100, then 16'h0600.
REQ-033 Reset asserted during SHIFT -> all outputs 0 immediately, no bcd_valid; next strobe din=80 -> bcd=16'h0010 after 14 edges.

Source files
------------

// File: rtl/filtro_media_bcd.sv
// Moving-average filter over ADC samples with a serial double-dabble
// binary-to-BCD converter that runs on each new average.
module filtro_media_bcd #(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] din,
    input  logic        din_valid,
    output logic [11:0] media,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);

    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = 12 + AVG_LOG2;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    logic [11:0]         buf_q [Depth];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [SumW-1:0]     sum_q, sum_d;

    state_e      state_q, state_d;
    logic [27:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic [27:0] adj;

    // Running sum: add the new sample, drop the one it overwrites (modular arithmetic is exact).
    always_comb begin
        sum_d = sum_q + SumW'(din) - SumW'(buf_q[ptr_q]);
    end

    // Circular sample buffer, write pointer and running sum; never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
        end else if (din_valid) begin
            buf_q[ptr_q] <= din;
            ptr_q        <= ptr_q + AVG_LOG2'(1);
            sum_q        <= sum_d;
        end
    end

    assign media = sum_q[SumW-1:AVG_LOG2];

    // Conversion FSM next-state: load, 12 dabble iterations, publish, then retrigger if asked.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        adj         = work_q;
        unique case (state_q)
            StIdle: begin
                if (din_valid) state_d = StLoad;
            end
            StLoad: begin
                work_d  = {16'h0000, media};
                cnt_d   = 4'd0;
                state_d = StShift;
                if (din_valid) pend_d = 1'b1;
            end
            StShift: begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[12+4*i +: 4] >= 4'd5) adj[12+4*i +: 4] = adj[12+4*i +: 4] + 4'd3;
                end
                work_d = {adj[26:0], 1'b0};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd11) state_d = StDone;
                if (din_valid) pend_d = 1'b1;
            end
            StDone: begin
                bcd_d       = work_q[27:12];
                bcd_valid_d = 1'b1;
                // A strobe arriving in this very cycle is folded into the retrigger.
                if (pend_q || din_valid) begin
                    state_d = StLoad;
                    pend_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Conversion FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            work_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_filtro_media_bcd.sv
// Self-checking bench for filtro_media_bcd: a window/timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_filtro_media_bcd;

    localparam int unsigned AvgLog2 = 3;
    localparam int unsigned Depth   = 1 << AvgLog2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] din = '0;
    logic        din_valid = 1'b0;
    logic [11:0] media;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    filtro_media_bcd #(.AVG_LOG2(AvgLog2)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .media     (media),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned win[$];   // last Depth samples; missing ones count as zero
    logic        m_active;
    int          m_phase;  // edges since the edge that started the conversion
    logic        m_pend;
    int          m_cap;
    int          m_pre;
    logic [15:0] m_bcd;
    logic        m_bcd_valid;

    function automatic int win_media();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s / Depth;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Timeline: the average is captured one edge after the start, published 14 edges after it.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            win.delete();
            m_active    = 1'b0;
            m_phase     = 0;
            m_pend      = 1'b0;
            m_cap       = 0;
            m_bcd       = '0;
            m_bcd_valid = 1'b0;
        end else begin
            m_pre       = win_media();
            m_bcd_valid = 1'b0;
            if (m_active) begin
                m_phase++;
                if (m_phase == 1) m_cap = m_pre;
                if (m_phase == 14) begin
                    m_bcd       = to_bcd(m_cap);
                    m_bcd_valid = 1'b1;
                    if (m_pend || din_valid) begin
                        m_phase = 0;
                        m_pend  = 1'b0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else if (din_valid) begin
                    m_pend = 1'b1;
                end
            end else if (din_valid) begin
                m_active = 1'b1;
                m_phase  = 0;
            end
            if (din_valid) begin
                win.push_back(din);
                if (win.size() > Depth) void'(win.pop_front());
            end
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        check("model_media", media, win_media());
        check("model_busy", busy, m_active);
        check("model_bcd_valid", bcd_valid, m_bcd_valid);
        check("model_bcd", bcd, m_bcd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input int v);
        @(negedge clk);
        din       = 12'(v);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_bcd(output int cyc);
        cyc = 0;
        while (!bcd_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_media", media, 0);
        check("rst_bcd", bcd, 0);
        check("rst_bcd_valid", bcd_valid, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    int          lat;
    int          np;
    logic [15:0] vals[2];
    int          exp030[8] = '{511, 1023, 1535, 2047, 2559, 3071, 3583, 4095};

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        check("init_media", media, 0);
        check("init_bcd", bcd, 0);
        check("init_busy", busy, 0);
        @(negedge clk);
        #2 reset = 1'b1;

        // Single sample 2000: average 250, converted after 14 edges.
        strobe(2000);
        check("s1_media", media, 250);
        check("s1_busy", busy, 1);
        wait_bcd(lat);
        check("s1_latency", lat, 14);
        check("s1_bcd", bcd, 16'h0250);
        @(negedge clk);
        check("s1_pulse_width", bcd_valid, 0);
        check("s1_bcd_hold", bcd, 16'h0250);

        // Full-scale ramp.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            strobe(4095);
            check("s2_media", media, exp030[k]);
            repeat (19) @(negedge clk);
        end
        check("s2_bcd", bcd, 16'h4095);

        // Window wrap: fill with 1000, then flush with 0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            strobe(1000);
            repeat (19) @(negedge clk);
        end
        check("s3_media_full", media, 1000);
        check("s3_bcd_full", bcd, 16'h1000);
        for (int k = 0; k < 8; k++) begin
            strobe(0);
            check("s3_media_drain", media, 1000 * (7 - k) / 8);
            repeat (19) @(negedge clk);
        end
        check("s3_bcd", bcd, 16'h0000);
        strobe(800);
        check("s3_media_after_wrap", media, 100);
        repeat (19) @(negedge clk);

        // Back-to-back strobes collapse into one follow-up conversion.
        do_reset();
        @(negedge clk);
        din = 12'd800;
        din_valid = 1'b1;
        @(negedge clk);
        din = 12'd1600;
        @(negedge clk);
        din = 12'd2400;
        @(negedge clk);
        din_valid = 1'b0;
        np = 0;
        vals[0] = '0;
        vals[1] = '0;
        for (int i = 0; i < 40; i++) begin
            if (bcd_valid) begin
                if (np < 2) vals[np] = bcd;
                np++;
            end
            @(negedge clk);
        end
        check("s4_pulses", np, 2);
        check("s4_bcd0", vals[0], 16'h0100);
        check("s4_bcd1", vals[1], 16'h0600);

        // Reset in the middle of a conversion.
        strobe(500);
        repeat (5) @(negedge clk);
        check("s5_busy_mid", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("s5_rst_media", media, 0);
        check("s5_rst_bcd", bcd, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_bcd_valid", bcd_valid, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        np = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bcd_valid) np++;
        end
        check("s5_no_pulse", np, 0);
        strobe(80);
        check("s5_media", media, 10);
        wait_bcd(lat);
        check("s5_latency", lat, 14);
        check("s5_bcd", bcd, 16'h0010);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
